riscv_muldiv_unit: RTL and testbench

// Iterative RV32M multiply/divide unit; successor to the single-cycle integer ALU.
// - Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a valid/ready handshake.
// - Sits beside the ALU in EX; the pipeline stalls while in_ready=0 or a result is pending.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/mdu_iter_step.sv | 54 +++++
 rtl/riscv_muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 execute-stage definitions: ALU op codes,
//               M-extension (MDU) funct3 codes and the MDU state encoding.
// Revision    : 1.0 - initial release with MDU support
// ============================================================================
package riscv_pkg;

  // Single-cycle ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // RV32M funct3 codes
  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  // Multiply/divide unit sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/mdu_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_step
// Description : One iteration of an unsigned shift-add multiply or restoring
//               divide on the {acc, q} register pair (2*LEN bits total).
//               Multiply: q holds the multiplier, low bits of the product
//               shift into q from acc. Divide: q holds the dividend and
//               collects quotient bits, acc holds the partial remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter_step #(
  parameter int LEN = 32
) (
  input  logic           is_div,
  input  logic [LEN-1:0] acc_i,
  input  logic [LEN-1:0] q_i,
  input  logic [LEN-1:0] opnd_i,
  output logic [LEN-1:0] acc_o,
  output logic [LEN-1:0] q_o
);

  logic [LEN:0]   sum;
  logic [LEN:0]   sh;
  logic [LEN-1:0] diff;

  // One multiply or divide iteration
  always_comb begin
    sum   = '0;
    sh    = '0;
    diff  = '0;
    acc_o = acc_i;
    q_o   = q_i;
    if (is_div) begin
      // Shift the next dividend bit into the partial remainder, then try to subtract.
      sh   = {acc_i, q_i[LEN-1]};
      // When the subtraction succeeds the difference is below the divisor, so LEN bits suffice.
      diff = sh[LEN-1:0] - opnd_i;
      if (sh >= {1'b0, opnd_i}) begin
        acc_o = diff;
        q_o   = {q_i[LEN-2:0], 1'b1};
      end else begin
        acc_o = sh[LEN-1:0];
        q_o   = {q_i[LEN-2:0], 1'b0};
      end
    end else begin
      // Conditionally add the multiplicand, keep the carry, shift right by one.
      sum   = q_i[0] ? ({1'b0, acc_i} + {1'b0, opnd_i}) : {1'b0, acc_i};
      acc_o = sum[LEN:1];
      q_o   = {sum[0], q_i[LEN-1:1]};
    end
  end

endmodule : mdu_iter_step
`default_nettype wire

// File: rtl/riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Operands are turned into
//               magnitudes at accept, LEN unsigned iterations run one per
//               cycle, and the sign is applied alongside the last iteration.
//               Divide-by-zero and signed overflow complete immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [LEN-1:0] A,
  input  logic [LEN-1:0] B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] result,
  output logic           zero
);

  localparam int CNT_W = $clog2(LEN) + 1;
  localparam logic [LEN-1:0] MIN_NEG = {1'b1, {(LEN-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN-1:0]   acc_q, acc_d;
  logic [LEN-1:0]   q_q, q_d;
  logic [LEN-1:0]   opnd_q, opnd_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;     // product / quotient negative
  logic             rneg_q, rneg_d;   // remainder negative (follows A)
  logic [LEN-1:0]   result_q, result_d;

  logic [LEN-1:0]   step_acc, step_q;

  // Accept-time decode
  logic             a_signed, b_signed, sgn_a, sgn_b;
  logic [LEN-1:0]   mag_a, mag_b;
  logic             div_zero, div_ovf;
  logic [LEN-1:0]   fast_res;

  // Final-cycle sign fix
  logic [2*LEN-1:0] prod_s;
  logic [LEN-1:0]   quo_s, rem_s, final_res;

  mdu_iter_step #(.LEN(LEN)) u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .q_i    (q_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .q_o    (step_q)
  );

  // Decode incoming operands: signedness, magnitudes and the immediate-result cases
  always_comb begin
    a_signed = (op != MDU_MULHU) && (op != MDU_DIVU) && (op != MDU_REMU);
    b_signed = (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    sgn_a    = a_signed && A[LEN-1];
    sgn_b    = b_signed && B[LEN-1];
    mag_a    = sgn_a ? (~A + 1'b1) : A;
    mag_b    = sgn_b ? (~B + 1'b1) : B;
    div_zero = op[2] && (B == '0);
    div_ovf  = ((op == MDU_DIV) || (op == MDU_REM)) && (A == MIN_NEG) && (B == '1);
    fast_res = '0;
    if (div_zero) begin
      fast_res = op[1] ? A : '1;
    end else if (div_ovf) begin
      fast_res = op[1] ? '0 : A;
    end
  end

  // Apply signs to the outcome of the last iteration and select the rd value
  always_comb begin
    prod_s    = neg_q ? (~{step_acc, step_q} + 1'b1) : {step_acc, step_q};
    quo_s     = neg_q ? (~step_q + 1'b1) : step_q;
    rem_s     = rneg_q ? (~step_acc + 1'b1) : step_acc;
    final_res = '0;
    if (op_q[2]) begin
      final_res = op_q[1] ? rem_s : quo_s;
    end else begin
      final_res = (op_q == MDU_MUL) ? prod_s[LEN-1:0] : prod_s[2*LEN-1:LEN];
    end
  end

  // Next-state and datapath update; flush overrides everything except the result register
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = op;
          neg_d  = sgn_a ^ sgn_b;
          rneg_d = sgn_a;
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            acc_d   = '0;
            q_d     = mag_a;
            opnd_d  = mag_b;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LEN - 1)) begin
          result_d = final_res;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule : riscv_muldiv_unit
`default_nettype wire

// File: tb/tb_riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_muldiv_unit
// Description : Directed bench for riscv_muldiv_unit with an arithmetic
//               reference model and a per-cycle output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_muldiv_unit;

  localparam int LEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'd0;
  logic [LEN-1:0]  A = '0;
  logic [LEN-1:0]  B = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [LEN-1:0]  result;
  logic            zero;

  riscv_muldiv_unit #(.LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;

  // Scoreboard for the op in flight
  logic        pend = 1'b0;
  logic        seen = 1'b0;
  int          cyc = 0;
  int          exp_cyc = 0;
  logic [31:0] exp_res = '0;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cycle in which out_valid first appears; the accept cycle is cycle 0
  function automatic int model_cyc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return LEN + 1;
  endfunction

  // Per-cycle output monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend) begin
        cyc++;
        if (out_valid) begin
          if (!seen) chk("latency", cyc, exp_cyc);
          chk("result", result, exp_res);
          chk("zero", {31'd0, zero}, {31'd0, exp_res == 0});
          chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
          seen = 1'b1;
        end else if (seen) begin
          pend = 1'b0;
        end else if (cyc > exp_cyc) begin
          chk("late_out_valid", {31'd0, out_valid}, 32'd1);
          pend = 1'b0;
        end
      end else if (out_valid) begin
        chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end
    end
  end

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #2;
    exp_res = model(o, a, b);
    exp_cyc = model_cyc(o, a, b);
    cyc = 0; seen = 1'b0; pend = 1'b1;
    in_valid = 1'b0;
    // Later operand changes must not affect the op in flight
    op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic finish_op(input int hold, input logic [31:0] lit);
    logic [31:0] got;
    int n;
    n = 0;
    while (!seen && n < 60) begin
      @(posedge clk); #2; n++;
    end
    if (!seen) begin
      chk("timeout_out_valid", {31'd0, seen}, 32'd1);
      pend = 1'b0;
      return;
    end
    got = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      in_valid = 1'b1; op = 3'($urandom); A = $urandom; B = $urandom;
      chk("in_ready_hold", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (pend && n < 5) begin
      @(posedge clk); #2; n++;
    end
    out_ready = 1'b0;
    chk("taken", {31'd0, pend}, 32'd0);
    chk("literal", got, lit);
    last_res = got;
    pend = 1'b0;
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int hold, input logic [31:0] lit);
    start_op(o, a, b);
    finish_op(hold, lit);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run(3'd0, 32'd7,         32'hFFFF_FFFD, 0, 32'hFFFF_FFEB);
    run(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h7FFF_FFFF);
    run(3'd4, 32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFD);
    run(3'd6, 32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFF);
    run(3'd5, 32'hFFFF_FFFF, 32'h10,        0, 32'h0FFF_FFFF);
    run(3'd4, 32'd5,         32'd0,         0, 32'hFFFF_FFFF);
    run(3'd7, 32'd5,         32'd0,         0, 32'd5);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
    run(3'd7, 32'd256,       32'd7,         0, 32'd4);
    run(3'd6, 32'd7,         32'hFFFF_FFFE, 0, 32'd1);
    run(3'd5, 32'd5,         32'd0,         0, 32'hFFFF_FFFF);
    run(3'd0, 32'd0,         32'h1234_5678, 0, 32'd0);

    // Backpressure: result held for 10 cycles while new requests are offered
    run(3'd4, 32'd7,         32'hFFFF_FFFE, 10, 32'hFFFF_FFFD);

    // Flush during cycle 10 of a divide
    start_op(3'd5, 32'd1000, 32'd3);
    while (cyc < 10) begin
      @(posedge clk); #2;
    end
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    pend = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_result_kept", result, last_res);
    repeat (40) @(posedge clk);
    #2 chk("flush_idle", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset mid-multiply, then a normal op
    start_op(3'd0, 32'h0001_0003, 32'h0000_0101);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    pend = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_zero", {31'd0, zero}, 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    run(3'd0, 32'h0001_0003, 32'h0000_0101, 0, 32'h0101_0303);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule : tb_riscv_muldiv_unit
`default_nettype wire
